cart_megarom_mapper: RTL and testbench

Parametrised MSX MegaROM bank mapper, successor to the single-mode ASCII16 mapper. Each of NUM_CARTS cartridges has its own mapper mode and four 8 KB bank registers. Supported modes are ASCII8, ASCII16, Konami and Konami-SCC. The block translates CPU addresses 4000h-BFFFh into a flat ROM byte address and flags accesses that fall outside the ROM. It sits between the slot decoder (which supplies cs/cart_num) and the cartridge ROM/SDRAM address path.

---
 rtl/cart_megarom_mapper.sv | 129 ++++++++++++
 tb/tb_cart_megarom_mapper.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cart_megarom_mapper.sv
// MSX MegaROM bank mapper: per-cart ASCII8/ASCII16/Konami/Konami-SCC bank registers and address translation.
// Optional SCC register window decode is enabled by defining MEGAROM_SCC_EN.
module cart_megarom_mapper #(
  parameter int NUM_CARTS = 2,
  parameter int ADDR_W    = 25,
  parameter int CN_W      = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*NUM_CARTS-1:0] i_mode,
  input  logic [ADDR_W-1:0]      i_rom_size,
  input  logic [15:0]            i_cpu_addr,
  input  logic [7:0]             i_din,
  input  logic                   i_cpu_mreq,
  input  logic                   i_cpu_wr,
  input  logic                   i_cs,
  input  logic [CN_W-1:0]        i_cart_num,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic                   o_mem_unmapped,
  output logic                   o_scc_cs
);

  localparam logic [1:0] M_ASCII8  = 2'd0;
  localparam logic [1:0] M_ASCII16 = 2'd1;
  localparam logic [1:0] M_KONAMI  = 2'd2;
  localparam logic [1:0] M_SCC     = 2'd3;

  function automatic logic [7:0] init_bank(input logic [1:0] m, input logic [1:0] k);
    case (m)
      M_ASCII8:  init_bank = 8'h00;
      M_ASCII16: init_bank = {7'b0, k[0]};
      default:   init_bank = {6'b0, k};
    endcase
  endfunction

  logic [7:0] r_bank   [NUM_CARTS][4];
  logic [1:0] r_mode_q [NUM_CARTS];

  logic        w_cart_ok;
  logic [1:0]  w_sel_mode;
  logic [7:0]  w_sel_bank [4];
  logic [3:0]  w_we;
  logic [7:0]  w_wd [4];
  logic        w_wr;
  logic [4:0]  w_a5;
  logic [2:0]  w_a3;
  logic        w_in_win;
  logic [1:0]  w_page;
  logic [20:0] w_rom_addr;
  logic        w_scc_hit;

  assign w_a5 = i_cpu_addr[15:11];
  assign w_a3 = i_cpu_addr[15:13];

  always_comb begin
    w_cart_ok  = 1'b0;
    w_sel_mode = '0;
    for (int k = 0; k < 4; k++) w_sel_bank[k] = '0;
    for (int c = 0; c < NUM_CARTS; c++) begin
      if (int'(i_cart_num) == c) begin
        w_cart_ok  = 1'b1;
        w_sel_mode = r_mode_q[c];
        for (int k = 0; k < 4; k++) w_sel_bank[k] = r_bank[c][k];
      end
    end
  end

  // Per-mode write decode; ASCII16 writes fill an even/odd pair of 8 KB registers.
  always_comb begin
    w_we = 4'b0000;
    for (int k = 0; k < 4; k++) w_wd[k] = i_din;
    case (w_sel_mode)
      M_ASCII8: begin
        if (w_a3 == 3'b011) w_we[i_cpu_addr[12:11]] = 1'b1;
      end
      M_ASCII16: begin
        w_wd[0] = {i_din[6:0], 1'b0};
        w_wd[1] = {i_din[6:0], 1'b1};
        w_wd[2] = {i_din[6:0], 1'b0};
        w_wd[3] = {i_din[6:0], 1'b1};
        if (w_a5 == 5'b01100) w_we[1:0] = 2'b11;
        if (w_a5 == 5'b01110) w_we[3:2] = 2'b11;
      end
      M_KONAMI: begin
        if (w_a3 == 3'b011) w_we[1] = 1'b1;
        if (w_a3 == 3'b100) w_we[2] = 1'b1;
        if (w_a3 == 3'b101) w_we[3] = 1'b1;
      end
      default: begin
        if (w_a5 == 5'b01010) w_we[0] = 1'b1;
        if (w_a5 == 5'b01110) w_we[1] = 1'b1;
        if (w_a5 == 5'b10010) w_we[2] = 1'b1;
        if (w_a5 == 5'b10110) w_we[3] = 1'b1;
      end
    endcase
  end

  assign w_wr = i_cs & i_cpu_mreq & i_cpu_wr & w_cart_ok;

  // A mode change re-initialises the cart and swallows any write to it on that edge.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CARTS; c++) begin
      if (reset || (i_mode[2*c +: 2] != r_mode_q[c])) begin
        r_mode_q[c] <= i_mode[2*c +: 2];
        for (int k = 0; k < 4; k++) r_bank[c][k] <= init_bank(i_mode[2*c +: 2], 2'(k));
      end else if (w_wr && (int'(i_cart_num) == c)) begin
        for (int k = 0; k < 4; k++) begin
          if (w_we[k]) r_bank[c][k] <= w_wd[k];
        end
      end
    end
  end

  assign w_in_win   = (i_cpu_addr[15:14] == 2'b01) || (i_cpu_addr[15:14] == 2'b10);
  assign w_page     = {~i_cpu_addr[14], i_cpu_addr[13]};
  assign w_rom_addr = {w_sel_bank[w_page], i_cpu_addr[12:0]};
  assign o_mem_addr = (w_in_win && w_cart_ok) ? ADDR_W'(w_rom_addr) : '0;

`ifdef MEGAROM_SCC_EN
  assign w_scc_hit = w_cart_ok & (w_sel_mode == M_SCC) & (w_sel_bank[2][5:0] == 6'h3F) &
                     i_cs & i_cpu_mreq & (w_a5 == 5'b10011);
`else
  assign w_scc_hit = 1'b0;
`endif

  assign o_scc_cs       = w_scc_hit;
  assign o_mem_unmapped = i_cs & (~w_in_win | (o_mem_addr >= i_rom_size)) & ~w_scc_hit;

endmodule

// File: tb/tb_cart_megarom_mapper.sv
// Directed bench for cart_megarom_mapper: range-based behavioural model checked every cycle plus literal checks.
module tb_cart_megarom_mapper;
  localparam int NC = 2;
  localparam int AW = 25;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    mode;
  logic [AW-1:0] rom_size;
  logic [15:0]   cpu_addr;
  logic [7:0]    din;
  logic          cpu_mreq, cpu_wr, cs;
  logic [CW-1:0] cart_num;
  logic [AW-1:0] mem_addr;
  logic          mem_unmapped, scc_cs;

  int total = 0;
  int bad   = 0;

  cart_megarom_mapper #(.NUM_CARTS(NC), .ADDR_W(AW), .CN_W(CW)) dut (
    .clk(clk), .reset(reset), .i_mode(mode), .i_rom_size(rom_size),
    .i_cpu_addr(cpu_addr), .i_din(din), .i_cpu_mreq(cpu_mreq), .i_cpu_wr(cpu_wr),
    .i_cs(cs), .i_cart_num(cart_num), .o_mem_addr(mem_addr),
    .o_mem_unmapped(mem_unmapped), .o_scc_cs(scc_cs)
  );

  always #5 clk = ~clk;

  // Model state: bank numbers and last seen mode per cart.
  int mb [NC][4];
  int mq [NC];
  bit model_ok = 1'b0;

  function automatic int init_val(int m, int k);
    if (m == 0) return 0;
    if (m == 1) return k % 2;
    return k;
  endfunction

  function automatic int new_bank(int m, int a, int d, int k, int old);
    case (m)
      0: if (a >= 'h6000 && a <= 'h7FFF && (a - 'h6000) / 'h800 == k) return d;
      1: begin
        if (a >= 'h6000 && a <= 'h67FF && k < 2)  return (d % 128) * 2 + k;
        if (a >= 'h7000 && a <= 'h77FF && k >= 2) return (d % 128) * 2 + k - 2;
      end
      2: if (k >= 1 && a >= 'h4000 + k * 'h2000 && a < 'h6000 + k * 'h2000) return d;
      default: if (a >= 'h5000 + k * 'h2000 && a < 'h5800 + k * 'h2000) return d;
    endcase
    return old;
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (reset || int'(mode[2*c +: 2]) != mq[c]) begin
        mq[c] <= int'(mode[2*c +: 2]);
        for (int k = 0; k < 4; k++) mb[c][k] <= init_val(int'(mode[2*c +: 2]), k);
      end else if (cs && cpu_mreq && cpu_wr && int'(cart_num) == c) begin
        for (int k = 0; k < 4; k++)
          mb[c][k] <= new_bank(mq[c], int'(cpu_addr), int'(din), k, mb[c][k]);
      end
    end
    if (reset) model_ok <= 1'b1;
  end

  function automatic int exp_addr(int c, int a);
    if (c >= NC || a < 'h4000 || a > 'hBFFF) return 0;
    return mb[c][(a - 'h4000) / 'h2000] * 'h2000 + a % 'h2000;
  endfunction

  function automatic bit exp_scc(int c, int a);
`ifdef MEGAROM_SCC_EN
    return c < NC && mq[c] == 3 && (mb[c][2] % 64) == 63 && cs && cpu_mreq &&
           a >= 'h9800 && a <= 'h9FFF;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (model_ok) begin
      int  ea;
      bit  es, eu;
      ea = exp_addr(int'(cart_num), int'(cpu_addr));
      es = exp_scc(int'(cart_num), int'(cpu_addr));
      eu = cs && !es && (cpu_addr < 16'h4000 || cpu_addr > 16'hBFFF || ea >= int'(rom_size));
      total++;
      if (mem_addr !== AW'(ea)) begin
        bad++;
        $display("FAIL cyc_mem_addr t=%0t got=%0h want=%0h", $time, mem_addr, ea);
      end
      total++;
      if (mem_unmapped !== eu) begin
        bad++;
        $display("FAIL cyc_unmapped t=%0t got=%0b want=%0b", $time, mem_unmapped, eu);
      end
      total++;
      if (scc_cs !== es) begin
        bad++;
        $display("FAIL cyc_scc_cs t=%0t got=%0b want=%0b", $time, scc_cs, es);
      end
    end
  end

  task automatic step(input bit r, input logic [3:0] md, input bit s, input bit w,
                      input int cn, input int a, input int d);
    @(posedge clk);
    #1;
    reset    = r;
    mode     = md;
    cs       = s;
    cpu_mreq = s;
    cpu_wr   = w;
    cart_num = CW'(cn);
    cpu_addr = 16'(a);
    din      = 8'(d);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  initial begin
    reset = 1'b1; mode = 4'b0001; rom_size = AW'('h40000);
    cpu_addr = '0; din = '0; cpu_mreq = 1'b0; cpu_wr = 1'b0; cs = 1'b0; cart_num = '0;

    step(1, 4'b0001, 0, 0, 0, 0, 0);
    step(1, 4'b0001, 0, 0, 0, 0, 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_unmapped", int'(mem_unmapped), 0);
    chk("rst_scc", int'(scc_cs), 0);

    step(0, 4'b0001, 1, 0, 0, 'h8000, 0);  chk("a16_init_8000", int'(mem_addr), 'h0);
    chk("a16_init_unm", int'(mem_unmapped), 0);
    step(0, 4'b0001, 1, 0, 0, 'hA000, 0);  chk("a16_init_A000", int'(mem_addr), 'h2000);
    step(0, 4'b0001, 1, 1, 0, 'h7000, 'h05);
    step(0, 4'b0001, 1, 0, 0, 'hA123, 0);  chk("a16_wr_A123", int'(mem_addr), 'h16123);
    step(0, 4'b0001, 1, 0, 1, 'hA000, 0);  chk("c1_untouched", int'(mem_addr), 0);

    step(0, 4'b0001, 1, 1, 1, 'h7800, 'h12);
    step(0, 4'b0001, 1, 0, 1, 'hA000, 0);  chk("a8_c1_A000", int'(mem_addr), 'h24000);
    step(0, 4'b0001, 1, 0, 0, 'hA000, 0);  chk("a8_c0_A000", int'(mem_addr), 'h16000);

    step(0, 4'b0001, 1, 1, 0, 'h6000, 'h03); chk("same_cycle_old", int'(mem_addr), 'h2000);
    step(0, 4'b0001, 1, 0, 0, 'h6000, 0);  chk("a16_6000", int'(mem_addr), 'hE000);
    step(0, 4'b0001, 1, 1, 0, 'h6800, 'h7F);
    step(0, 4'b0001, 1, 0, 0, 'h4000, 0);  chk("a16_ign_6800", int'(mem_addr), 'hC000);

    step(0, 4'b0001, 1, 0, 0, 'h3000, 0);  chk("low_addr", int'(mem_addr), 0);
    chk("low_unm", int'(mem_unmapped), 1);
    step(0, 4'b0001, 0, 0, 0, 'h3000, 0);  chk("low_nocs_unm", int'(mem_unmapped), 0);
    step(0, 4'b0001, 1, 0, 0, 'hC000, 0);  chk("high_unm", int'(mem_unmapped), 1);

    step(0, 4'b0001, 1, 1, 2, 'h6000, 'h55);
    step(0, 4'b0001, 1, 0, 0, 'h6000, 0);  chk("bad_cart_wr", int'(mem_addr), 'hE000);
    step(0, 4'b0001, 1, 0, 2, 'h6000, 0);  chk("bad_cart_rd", int'(mem_addr), 0);

    step(0, 4'b1101, 0, 0, 0, 0, 0);
    step(0, 4'b1101, 1, 0, 1, 'hB000, 0);  chk("scc_init_B000", int'(mem_addr), 'h7000);
    rom_size = AW'('h80000);
    step(0, 4'b1101, 1, 1, 1, 'hB000, 'hFF);
    step(0, 4'b1101, 1, 0, 1, 'hB000, 0);  chk("scc_FF_addr", int'(mem_addr), 'h1FF000);
    chk("scc_FF_unm", int'(mem_unmapped), 1);
    step(0, 4'b1101, 1, 1, 1, 'hB000, 'h10);
    step(0, 4'b1101, 1, 0, 1, 'hB000, 0);  chk("scc_10_addr", int'(mem_addr), 'h21000);
    chk("scc_10_unm", int'(mem_unmapped), 0);
    rom_size = AW'('h21000); #1; chk("eq_rom_unm", int'(mem_unmapped), 1);
    rom_size = AW'('h21001); #1; chk("below_rom_unm", int'(mem_unmapped), 0);

    step(0, 4'b1100, 0, 0, 0, 0, 0);
    step(0, 4'b1110, 1, 1, 0, 'h6000, 'h07);
    step(0, 4'b1110, 1, 0, 0, 'h6000, 0);  chk("mchg_discard", int'(mem_addr), 'h2000);
    step(0, 4'b1110, 1, 0, 0, 'hA000, 0);  chk("kon_init_A000", int'(mem_addr), 'h6000);
    step(0, 4'b1110, 1, 1, 0, 'h6000, 'h07);
    step(0, 4'b1110, 1, 0, 0, 'h6000, 0);  chk("kon_6000", int'(mem_addr), 'hE000);
    step(0, 4'b1110, 1, 0, 0, 'h4000, 0);  chk("kon_bank0", int'(mem_addr), 0);
    step(0, 4'b1110, 1, 0, 1, 'hB000, 0);  chk("mchg_other_cart", int'(mem_addr), 'h21000);

    rom_size = AW'('h80000);
    step(0, 4'b1110, 1, 1, 1, 'h9000, 'h3F);
    step(0, 4'b1110, 1, 0, 1, 'h9800, 0);
`ifdef MEGAROM_SCC_EN
    chk("scc_win_on", int'(scc_cs), 1);
`else
    chk("scc_win_off", int'(scc_cs), 0);
    chk("scc_win_rom", int'(mem_addr), 'h7F800);
`endif
    chk("scc_win_unm", int'(mem_unmapped), 0);
    step(0, 4'b1110, 1, 1, 1, 'h9000, 'h3E);
    step(0, 4'b1110, 1, 0, 1, 'h9800, 0);  chk("scc_3E", int'(scc_cs), 0);

    step(1, 4'b1110, 1, 1, 1, 'hB000, 'h99);
    step(0, 4'b1110, 1, 0, 1, 'hB000, 0);  chk("rst_wins", int'(mem_addr), 'h7000);
    step(0, 4'b1110, 1, 0, 0, 'h6000, 0);  chk("rst_kon_c0", int'(mem_addr), 'h2000);

    step(0, 4'b1110, 0, 0, 0, 0, 0);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
